// File: rtl/rk_kbd_pkg.sv
// ----------------------------------------------------------------------------
// rk_kbd_pkg
//
// Shared definitions for the PS/2-to-matrix keyboard adapter:
//   - prefix_state_e : state of the scan-code prefix tracker
//   - CODE_*         : PS/2 scan-code bytes with special meaning
//   - map_entry_t    : result of a {ext, code} layout lookup
//   - mk_entry()     : builds a valid map entry from a row/column pair
//   - is_flush_code(): bytes that wipe the whole key matrix
// ----------------------------------------------------------------------------
package rk_kbd_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_EXT    = 3'd1,
        ST_REL    = 3'd2,
        ST_EXTREL = 3'd3,
        ST_SKIP   = 3'd4
    } prefix_state_e;

    localparam logic [7:0] CODE_E0 = 8'hE0;
    localparam logic [7:0] CODE_F0 = 8'hF0;
    localparam logic [7:0] CODE_E1 = 8'hE1;
    localparam logic [7:0] CODE_AA = 8'hAA;
    localparam logic [7:0] CODE_00 = 8'h00;
    localparam logic [7:0] CODE_FF = 8'hFF;

    // The Pause key sends E1 followed by seven more bytes that carry no key.
    localparam int SKIP_LEN = 7;

    // Map fields are sized for the largest layout we expect to generate;
    // the top module narrows them to its own row/column widths.
    localparam int MAP_ROW_W = 4;
    localparam int MAP_COL_W = 4;

    typedef struct packed {
        logic                 valid;
        logic [MAP_ROW_W-1:0] row;
        logic [MAP_COL_W-1:0] col;
    } map_entry_t;

    function automatic map_entry_t mk_entry(input int row, input int col);
        map_entry_t e;
        e.valid = 1'b1;
        e.row   = MAP_ROW_W'(row);
        e.col   = MAP_COL_W'(col);
        return e;
    endfunction

    // BAT completion and the two overrun codes all mean the keyboard has
    // lost or reset its own state, so ours must be dropped too.
    function automatic logic is_flush_code(input logic [7:0] b);
        return (b == CODE_AA) || (b == CODE_00) || (b == CODE_FF);
    endfunction

endpackage

// File: rtl/rk_kbd_map.sv
// ----------------------------------------------------------------------------
// rk_kbd_map
//
// Purely combinational scan-code to matrix-position lookup for the
// Radio-86RK 8x8 layout plus the modifier row (row 8).
//
// Ports:
//   ext   in   1            E0 prefix was seen before this code
//   code  in   8            scan-code byte (set 2)
//   entry out  map_entry_t  {valid, row, col}; valid=0 for unmapped codes
//
// Modifier row: col 0 = Shift (either), col 1 = Ctrl (either),
//               col 2 = Rus/Lat (Caps Lock).
// ----------------------------------------------------------------------------
module rk_kbd_map
    import rk_kbd_pkg::*;
(
    input  logic       ext,
    input  logic [7:0] code,
    output map_entry_t entry
);

    // One case arm per physical key; the 9-bit selector is {ext, code}.
    always_comb begin
        entry = '0;
        case ({ext, code})
            // row 0: Home, Clr, Esc, F1..F5
            9'h16C: entry = mk_entry(0, 0);
            9'h169: entry = mk_entry(0, 1);
            9'h076: entry = mk_entry(0, 2);
            9'h005: entry = mk_entry(0, 3);
            9'h006: entry = mk_entry(0, 4);
            9'h004: entry = mk_entry(0, 5);
            9'h00C: entry = mk_entry(0, 6);
            9'h003: entry = mk_entry(0, 7);
            // row 1: Tab, LF, CR, BS, cursor keys
            9'h00D: entry = mk_entry(1, 0);
            9'h15A: entry = mk_entry(1, 1);
            9'h05A: entry = mk_entry(1, 2);
            9'h066: entry = mk_entry(1, 3);
            9'h16B: entry = mk_entry(1, 4);
            9'h175: entry = mk_entry(1, 5);
            9'h174: entry = mk_entry(1, 6);
            9'h172: entry = mk_entry(1, 7);
            // row 2: 0..7
            9'h045: entry = mk_entry(2, 0);
            9'h016: entry = mk_entry(2, 1);
            9'h01E: entry = mk_entry(2, 2);
            9'h026: entry = mk_entry(2, 3);
            9'h025: entry = mk_entry(2, 4);
            9'h02E: entry = mk_entry(2, 5);
            9'h036: entry = mk_entry(2, 6);
            9'h03D: entry = mk_entry(2, 7);
            // row 3: 8 9 : ; , - . /
            9'h03E: entry = mk_entry(3, 0);
            9'h046: entry = mk_entry(3, 1);
            9'h052: entry = mk_entry(3, 2);
            9'h04C: entry = mk_entry(3, 3);
            9'h041: entry = mk_entry(3, 4);
            9'h04E: entry = mk_entry(3, 5);
            9'h049: entry = mk_entry(3, 6);
            9'h04A: entry = mk_entry(3, 7);
            // row 4: @ A B C D E F G
            9'h00E: entry = mk_entry(4, 0);
            9'h01C: entry = mk_entry(4, 1);
            9'h032: entry = mk_entry(4, 2);
            9'h021: entry = mk_entry(4, 3);
            9'h023: entry = mk_entry(4, 4);
            9'h024: entry = mk_entry(4, 5);
            9'h02B: entry = mk_entry(4, 6);
            9'h034: entry = mk_entry(4, 7);
            // row 5: H I J K L M N O
            9'h033: entry = mk_entry(5, 0);
            9'h043: entry = mk_entry(5, 1);
            9'h03B: entry = mk_entry(5, 2);
            9'h042: entry = mk_entry(5, 3);
            9'h04B: entry = mk_entry(5, 4);
            9'h03A: entry = mk_entry(5, 5);
            9'h031: entry = mk_entry(5, 6);
            9'h044: entry = mk_entry(5, 7);
            // row 6: P Q R S T U V W
            9'h04D: entry = mk_entry(6, 0);
            9'h015: entry = mk_entry(6, 1);
            9'h02D: entry = mk_entry(6, 2);
            9'h01B: entry = mk_entry(6, 3);
            9'h02C: entry = mk_entry(6, 4);
            9'h03C: entry = mk_entry(6, 5);
            9'h02A: entry = mk_entry(6, 6);
            9'h01D: entry = mk_entry(6, 7);
            // row 7: X Y Z [ \ ] ^ space
            9'h022: entry = mk_entry(7, 0);
            9'h035: entry = mk_entry(7, 1);
            9'h01A: entry = mk_entry(7, 2);
            9'h054: entry = mk_entry(7, 3);
            9'h05D: entry = mk_entry(7, 4);
            9'h05B: entry = mk_entry(7, 5);
            9'h055: entry = mk_entry(7, 6);
            9'h029: entry = mk_entry(7, 7);
            // modifier row
            9'h012: entry = mk_entry(8, 0);
            9'h059: entry = mk_entry(8, 0);
            9'h014: entry = mk_entry(8, 1);
            9'h114: entry = mk_entry(8, 1);
            9'h058: entry = mk_entry(8, 2);
            default: entry = '0;
        endcase
    end

endmodule

// File: rtl/rk_kbd_matrix.sv
// ----------------------------------------------------------------------------
// rk_kbd_matrix
//
// PS/2 keyboard to ROWS x COLS key-matrix adapter with a modifier row.
//
// Ports:
//   clk, reset_n      system clock, asynchronous active-low reset
//   ps2_clk, ps2_dat  raw PS/2 lines (asynchronous to clk)
//   addr   [ROWS]     row select, one bit per row, selected rows are OR-ed
//   odata  [COLS]     key bits of the selected rows (inverted if ACTIVE_LOW)
//   shift  [MODS]     modifier row bits
//   key_evt           one-cycle pulse per mapped make/break
//   key_row, key_col  position of the last event (row ROWS = modifier row)
//   key_rel           last event was a release
//   frame_err         one-cycle pulse on a bad frame or frame timeout
// ----------------------------------------------------------------------------
module rk_kbd_matrix
    import rk_kbd_pkg::*;
#(
    parameter  int ROWS       = 8,
    parameter  int COLS       = 8,
    parameter  int MODS       = 3,
    parameter  int FILT       = 4,
    parameter  int TIMEOUT    = 2000,
    parameter  bit ACTIVE_LOW = 1'b0,
    localparam int ROW_W      = $clog2(ROWS + 1),
    localparam int COL_W      = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             ps2_clk,
    input  logic             ps2_dat,
    input  logic [ROWS-1:0]  addr,
    output logic [COLS-1:0]  odata,
    output logic [MODS-1:0]  shift,
    output logic             key_evt,
    output logic [ROW_W-1:0] key_row,
    output logic [COL_W-1:0] key_col,
    output logic             key_rel,
    output logic             frame_err
);

    localparam int FILT_W = $clog2(FILT);
    localparam int WD_W   = $clog2(TIMEOUT + 1);

    // ------------------------------------------------------------------
    // Signals
    // ------------------------------------------------------------------
    logic                      ps2_clk_s1_q, ps2_clk_s2_q;
    logic                      ps2_dat_s1_q, ps2_dat_s2_q;

    logic                      clk_filt_q, clk_filt_d;
    logic [FILT_W-1:0]         filt_cnt_q, filt_cnt_d;
    logic                      edge_evt;

    logic [9:0]                frame_q, frame_d;
    logic [10:0]               full_frame;
    logic [3:0]                bit_cnt_q, bit_cnt_d;
    logic [WD_W-1:0]           wd_cnt_q, wd_cnt_d;
    logic                      byte_strb;
    logic                      bad_frame;
    logic                      timeout;
    logic [7:0]                byte_val;

    prefix_state_e             state_q, state_d;
    logic [2:0]                skip_cnt_q, skip_cnt_d;
    logic                      ext_now, rel_now;

    map_entry_t                entry;
    logic                      map_hit;
    logic [ROW_W-1:0]          row_idx;
    logic [COL_W-1:0]          col_idx;

    logic [ROWS:0][COLS-1:0]   keystate_q, keystate_d;
    logic                      key_evt_q, key_evt_d;
    logic                      key_rel_q, key_rel_d;
    logic                      frame_err_q, frame_err_d;
    logic [ROW_W-1:0]          key_row_q, key_row_d;
    logic [COL_W-1:0]          key_col_q, key_col_d;

    logic [ROWS-1:0]           row_sel;
    logic [COLS-1:0]           row_or;

    // ------------------------------------------------------------------
    // Synchronisers. Idle PS/2 lines are high, so reset to 1 to avoid a
    // phantom falling edge right after reset.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ps2_clk_s1_q <= 1'b1;
            ps2_clk_s2_q <= 1'b1;
            ps2_dat_s1_q <= 1'b1;
            ps2_dat_s2_q <= 1'b1;
        end else begin
            ps2_clk_s1_q <= ps2_clk;
            ps2_clk_s2_q <= ps2_clk_s1_q;
            ps2_dat_s1_q <= ps2_dat;
            ps2_dat_s2_q <= ps2_dat_s1_q;
        end
    end

    // ------------------------------------------------------------------
    // Glitch filter: the filtered level only flips once FILT consecutive
    // samples disagree with it; any agreeing sample restarts the count.
    // ------------------------------------------------------------------
    always_comb begin
        clk_filt_d = clk_filt_q;
        filt_cnt_d = '0;
        if (ps2_clk_s2_q != clk_filt_q) begin
            if (filt_cnt_q == FILT_W'(FILT - 1)) begin
                clk_filt_d = ps2_clk_s2_q;
            end else begin
                filt_cnt_d = filt_cnt_q + 1'b1;
            end
        end
        edge_evt = clk_filt_q & ~clk_filt_d;
    end

    // ------------------------------------------------------------------
    // Deserialiser and watchdog. Bits arrive LSB first; the frame register
    // keeps the previous ten bits so that at the stop bit the complete
    // frame is {stop, parity, data[7:0], start}. An edge event always takes
    // priority over a simultaneous timeout.
    // ------------------------------------------------------------------
    always_comb begin
        frame_d    = frame_q;
        bit_cnt_d  = bit_cnt_q;
        wd_cnt_d   = wd_cnt_q;
        byte_strb  = 1'b0;
        bad_frame  = 1'b0;
        timeout    = 1'b0;
        full_frame = {ps2_dat_s2_q, frame_q};
        byte_val   = full_frame[8:1];

        if (edge_evt) begin
            frame_d  = full_frame[10:1];
            wd_cnt_d = '0;
            if (bit_cnt_q == 4'd10) begin
                bit_cnt_d = '0;
                if (!full_frame[0] && full_frame[10] && (^full_frame[9:1])) begin
                    byte_strb = 1'b1;
                end else begin
                    bad_frame = 1'b1;
                end
            end else begin
                bit_cnt_d = bit_cnt_q + 1'b1;
            end
        end else if (bit_cnt_q != 4'd0) begin
            if (wd_cnt_q == WD_W'(TIMEOUT - 1)) begin
                timeout   = 1'b1;
                bit_cnt_d = '0;
                wd_cnt_d  = '0;
            end else begin
                wd_cnt_d = wd_cnt_q + 1'b1;
            end
        end else begin
            wd_cnt_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // Layout lookup. Entries pointing outside this instance's matrix are
    // treated as misses so a wider generated map cannot corrupt state.
    // ------------------------------------------------------------------
    assign ext_now = (state_q == ST_EXT) || (state_q == ST_EXTREL);
    assign rel_now = (state_q == ST_REL) || (state_q == ST_EXTREL);

    rk_kbd_map u_map (
        .ext   (ext_now),
        .code  (byte_val),
        .entry (entry)
    );

    assign map_hit = entry.valid && (int'(entry.row) <= ROWS) && (int'(entry.col) < COLS);
    assign row_idx = ROW_W'(entry.row);
    assign col_idx = COL_W'(entry.col);

    // ------------------------------------------------------------------
    // Prefix tracker and key matrix update. E0 and F0 accumulate into the
    // ext/rel flags in either order; E1 swallows the rest of the Pause
    // sequence. Flush codes win over every state.
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        skip_cnt_d  = skip_cnt_q;
        keystate_d  = keystate_q;
        key_evt_d   = 1'b0;
        key_rel_d   = key_rel_q;
        key_row_d   = key_row_q;
        key_col_d   = key_col_q;
        frame_err_d = bad_frame | timeout;

        if (byte_strb) begin
            if (is_flush_code(byte_val)) begin
                keystate_d = '0;
                state_d    = ST_IDLE;
                skip_cnt_d = '0;
            end else if (state_q == ST_SKIP) begin
                skip_cnt_d = skip_cnt_q - 1'b1;
                if (skip_cnt_q == 3'd1) begin
                    state_d = ST_IDLE;
                end
            end else if (byte_val == CODE_E1) begin
                state_d    = ST_SKIP;
                skip_cnt_d = 3'(SKIP_LEN);
            end else if (byte_val == CODE_E0) begin
                state_d = rel_now ? ST_EXTREL : ST_EXT;
            end else if (byte_val == CODE_F0) begin
                state_d = ext_now ? ST_EXTREL : ST_REL;
            end else begin
                state_d = ST_IDLE;
                if (map_hit) begin
                    keystate_d[row_idx][col_idx] = ~rel_now;
                    key_evt_d = 1'b1;
                    key_row_d = row_idx;
                    key_col_d = col_idx;
                    key_rel_d = rel_now;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_filt_q  <= 1'b1;
            filt_cnt_q  <= '0;
            frame_q     <= '0;
            bit_cnt_q   <= '0;
            wd_cnt_q    <= '0;
            state_q     <= ST_IDLE;
            skip_cnt_q  <= '0;
            keystate_q  <= '0;
            key_evt_q   <= 1'b0;
            key_rel_q   <= 1'b0;
            key_row_q   <= '0;
            key_col_q   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            clk_filt_q  <= clk_filt_d;
            filt_cnt_q  <= filt_cnt_d;
            frame_q     <= frame_d;
            bit_cnt_q   <= bit_cnt_d;
            wd_cnt_q    <= wd_cnt_d;
            state_q     <= state_d;
            skip_cnt_q  <= skip_cnt_d;
            keystate_q  <= keystate_d;
            key_evt_q   <= key_evt_d;
            key_rel_q   <= key_rel_d;
            key_row_q   <= key_row_d;
            key_col_q   <= key_col_d;
            frame_err_q <= frame_err_d;
        end
    end

    // ------------------------------------------------------------------
    // Host scan port: purely combinational so the host sees its row
    // select reflected in the same cycle.
    // ------------------------------------------------------------------
    always_comb begin
        row_sel = ACTIVE_LOW ? ~addr : addr;
        row_or  = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (row_sel[r]) begin
                row_or = row_or | keystate_q[r];
            end
        end
        odata = ACTIVE_LOW ? ~row_or : row_or;
    end

    assign shift     = keystate_q[ROWS][MODS-1:0];
    assign key_evt   = key_evt_q;
    assign key_row   = key_row_q;
    assign key_col   = key_col_q;
    assign key_rel   = key_rel_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_rk_kbd_matrix.sv
// ----------------------------------------------------------------------------
// tb_rk_kbd_matrix
//
// Directed bench for rk_kbd_matrix. Two instances share the PS/2 lines:
// dut (active-high scan port) and dut_al (ACTIVE_LOW=1). Expected values
// are hand-computed from the Radio-86RK layout ('A' = row 4 col 1,
// space = row 7 col 7, Shift/Ctrl = modifier row cols 0/1).
// ----------------------------------------------------------------------------
module tb_rk_kbd_matrix;

    localparam int ROWS     = 8;
    localparam int COLS     = 8;
    localparam int MODS     = 3;
    localparam int FILT     = 4;
    localparam int TIMEOUT  = 2000;
    localparam int HALF_BIT = 20;

    logic       clk     = 1'b0;
    logic       reset_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] addr    = 8'h00;
    logic [7:0] addr_al = 8'hFF;

    logic [7:0] odata,     odata_al;
    logic [2:0] shift,     shift_al;
    logic       key_evt,   key_evt_al;
    logic [3:0] key_row,   key_row_al;
    logic [2:0] key_col,   key_col_al;
    logic       key_rel,   key_rel_al;
    logic       frame_err, frame_err_al;

    int n_compared = 0;
    int n_mismatch = 0;

    int cyc          = 0;
    int fall_cyc     = 0;
    int evt_cnt      = 0;
    int err_cnt      = 0;
    int evt_cnt_al   = 0;
    int err_cnt_al   = 0;
    int last_evt_cyc = 0;
    logic [3:0] last_row = '0;
    logic [2:0] last_col = '0;
    logic       last_rel = 1'b0;

    rk_kbd_matrix #(
        .ROWS(ROWS), .COLS(COLS), .MODS(MODS), .FILT(FILT),
        .TIMEOUT(TIMEOUT), .ACTIVE_LOW(1'b0)
    ) dut (
        .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .addr(addr), .odata(odata), .shift(shift), .key_evt(key_evt),
        .key_row(key_row), .key_col(key_col), .key_rel(key_rel),
        .frame_err(frame_err)
    );

    rk_kbd_matrix #(
        .ROWS(ROWS), .COLS(COLS), .MODS(MODS), .FILT(FILT),
        .TIMEOUT(TIMEOUT), .ACTIVE_LOW(1'b1)
    ) dut_al (
        .clk(clk), .reset_n(reset_n), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
        .addr(addr_al), .odata(odata_al), .shift(shift_al), .key_evt(key_evt_al),
        .key_row(key_row_al), .key_col(key_col_al), .key_rel(key_rel_al),
        .frame_err(frame_err_al)
    );

    always #5 clk = ~clk;

    // free-running cycle count used for latency measurement
    always @(posedge clk) cyc <= cyc + 1;

    // pulse monitors, sampled on the inactive edge
    always @(negedge clk) begin
        if (key_evt) begin
            evt_cnt      = evt_cnt + 1;
            last_evt_cyc = cyc;
            last_row     = key_row;
            last_col     = key_col;
            last_rel     = key_rel;
        end
        if (frame_err)    err_cnt    = err_cnt + 1;
        if (key_evt_al)   evt_cnt_al = evt_cnt_al + 1;
        if (frame_err_al) err_cnt_al = err_cnt_al + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatch++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // one PS/2 bit; optional 1-cycle glitches in both clock phases
    task automatic ps2Bit(input logic b, input bit glitch);
        ps2_dat = b;
        repeat (HALF_BIT / 2) @(posedge clk);
        if (glitch) begin
            #1 ps2_clk = 1'b0;
            @(posedge clk);
            #1 ps2_clk = 1'b1;
            repeat (3) @(posedge clk);
        end
        #1 ps2_clk = 1'b0;
        fall_cyc = cyc;
        repeat (HALF_BIT / 2) @(posedge clk);
        if (glitch) begin
            #1 ps2_clk = 1'b1;
            @(posedge clk);
            #1 ps2_clk = 1'b0;
        end
        repeat (HALF_BIT / 2) @(posedge clk);
        #1 ps2_clk = 1'b1;
        repeat (HALF_BIT / 2) @(posedge clk);
    endtask

    function automatic logic [10:0] mkFrame(input logic [7:0] b, input bit bad_par);
        return {1'b1, (~^b) ^ bad_par, b, 1'b0};
    endfunction

    task automatic applyStimulus(input logic [7:0] b, input bit bad_par, input bit glitch);
        logic [10:0] fr;
        fr = mkFrame(b, bad_par);
        for (int i = 0; i < 11; i++) ps2Bit(fr[i], glitch);
        repeat (HALF_BIT * 2) @(posedge clk);
        @(negedge clk);
    endtask

    task automatic sendPartial(input logic [7:0] b, input int nbits);
        logic [10:0] fr;
        fr = mkFrame(b, 1'b0);
        for (int i = 0; i < nbits; i++) ps2Bit(fr[i], 1'b0);
    endtask

    initial begin
        int ev0;
        int er0;
        int ev0_al;
        int lat;

        // reset values
        repeat (4) @(negedge clk);
        checkOutput("rst_odata",     32'(odata),     32'h00);
        checkOutput("rst_odata_al",  32'(odata_al),  32'hFF);
        checkOutput("rst_shift",     32'(shift),     32'h0);
        checkOutput("rst_key_evt",   32'(key_evt),   32'h0);
        checkOutput("rst_frame_err", 32'(frame_err), 32'h0);
        checkOutput("rst_key_pos",   32'({key_row, key_col, key_rel}), 32'h0);
        @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (10) @(posedge clk);

        // 'A' make, typematic repeat, break
        $display("[TB] A press/release");
        addr    = 8'h10;
        addr_al = 8'hEF;
        ev0 = evt_cnt;
        applyStimulus(8'h1C, 1'b0, 1'b0);
        lat = last_evt_cyc - fall_cyc;
        checkOutput("A_odata",     32'(odata),    32'h02);
        checkOutput("A_odata_al",  32'(odata_al), 32'hFD);
        checkOutput("A_evt_cnt",   32'(evt_cnt - ev0), 32'd1);
        checkOutput("A_evt_pos",   32'({last_row, last_col, last_rel}), 32'({4'd4, 3'd1, 1'b0}));
        checkOutput("A_latency",   32'((lat >= FILT + 1) && (lat <= FILT + 4)), 32'd1);
        addr = 8'h08;
        #1 checkOutput("A_other_row", 32'(odata), 32'h00);
        addr = 8'h10;
        applyStimulus(8'h1C, 1'b0, 1'b0);
        checkOutput("A_repeat_odata", 32'(odata), 32'h02);
        checkOutput("A_repeat_evt",   32'(evt_cnt - ev0), 32'd2);
        applyStimulus(8'hF0, 1'b0, 1'b0);
        applyStimulus(8'h1C, 1'b0, 1'b0);
        checkOutput("A_rel_odata",    32'(odata),    32'h00);
        checkOutput("A_rel_odata_al", 32'(odata_al), 32'hFF);
        checkOutput("A_rel_evt",      32'(evt_cnt - ev0), 32'd3);
        checkOutput("A_rel_pos",      32'({last_row, last_col, last_rel}), 32'({4'd4, 3'd1, 1'b1}));

        // modifiers and BAT flush
        $display("[TB] modifiers and flush");
        applyStimulus(8'hE0, 1'b0, 1'b0);
        applyStimulus(8'h14, 1'b0, 1'b0);
        checkOutput("rctrl_shift", 32'(shift), 32'h2);
        checkOutput("rctrl_pos",   32'({last_row, last_col, last_rel}), 32'({4'd8, 3'd1, 1'b0}));
        applyStimulus(8'h12, 1'b0, 1'b0);
        checkOutput("lshift_shift", 32'(shift), 32'h3);
        applyStimulus(8'h1C, 1'b0, 1'b0);
        addr = 8'hFF;
        #1 checkOutput("preflush_odata", 32'(odata), 32'h02);
        ev0 = evt_cnt;
        applyStimulus(8'hAA, 1'b0, 1'b0);
        checkOutput("flush_shift", 32'(shift), 32'h0);
        checkOutput("flush_odata", 32'(odata), 32'h00);
        checkOutput("flush_noevt", 32'(evt_cnt - ev0), 32'd0);

        // bad parity, then a good frame
        $display("[TB] bad parity");
        addr = 8'h10;
        er0 = err_cnt;
        ev0 = evt_cnt;
        applyStimulus(8'h1C, 1'b1, 1'b0);
        checkOutput("par_err_cnt", 32'(err_cnt - er0), 32'd1);
        checkOutput("par_odata",   32'(odata), 32'h00);
        checkOutput("par_noevt",   32'(evt_cnt - ev0), 32'd0);
        applyStimulus(8'h1C, 1'b0, 1'b0);
        checkOutput("par_good_odata", 32'(odata), 32'h02);
        checkOutput("par_good_err",   32'(err_cnt - er0), 32'd1);
        applyStimulus(8'hF0, 1'b0, 1'b0);
        applyStimulus(8'h1C, 1'b0, 1'b0);

        // frame timeout, then space
        $display("[TB] frame timeout");
        er0 = err_cnt;
        sendPartial(8'h29, 5);
        repeat (TIMEOUT + 10) @(posedge clk);
        @(negedge clk);
        checkOutput("to_err_cnt", 32'(err_cnt - er0), 32'd1);
        applyStimulus(8'h29, 1'b0, 1'b0);
        addr = 8'h80;
        #1 checkOutput("to_space_odata", 32'(odata), 32'h80);
        checkOutput("to_err_total", 32'(err_cnt - er0), 32'd1);
        applyStimulus(8'hF0, 1'b0, 1'b0);
        applyStimulus(8'h29, 1'b0, 1'b0);
        checkOutput("to_space_rel", 32'(odata), 32'h00);

        // Pause sequence is swallowed
        $display("[TB] pause skip");
        addr = 8'h10;
        ev0 = evt_cnt;
        applyStimulus(8'hE1, 1'b0, 1'b0);
        applyStimulus(8'h14, 1'b0, 1'b0);
        applyStimulus(8'h77, 1'b0, 1'b0);
        applyStimulus(8'hE1, 1'b0, 1'b0);
        applyStimulus(8'hF0, 1'b0, 1'b0);
        applyStimulus(8'h14, 1'b0, 1'b0);
        applyStimulus(8'hF0, 1'b0, 1'b0);
        applyStimulus(8'h77, 1'b0, 1'b0);
        checkOutput("pause_noevt", 32'(evt_cnt - ev0), 32'd0);
        checkOutput("pause_shift", 32'(shift), 32'h0);
        applyStimulus(8'h1C, 1'b0, 1'b0);
        checkOutput("pause_A_odata", 32'(odata), 32'h02);
        checkOutput("pause_A_evt",   32'(evt_cnt - ev0), 32'd1);
        applyStimulus(8'hF0, 1'b0, 1'b0);
        applyStimulus(8'h1C, 1'b0, 1'b0);

        // clock glitches shorter than the filter
        $display("[TB] glitch filter");
        er0 = err_cnt;
        ev0 = evt_cnt;
        applyStimulus(8'h32, 1'b0, 1'b1);
        checkOutput("glitch_odata", 32'(odata), 32'h04);
        checkOutput("glitch_pos",   32'({last_row, last_col, last_rel}), 32'({4'd4, 3'd2, 1'b0}));
        checkOutput("glitch_err",   32'(err_cnt - er0), 32'd0);
        applyStimulus(8'hF0, 1'b0, 1'b1);
        applyStimulus(8'h32, 1'b0, 1'b1);
        checkOutput("glitch_rel_odata", 32'(odata), 32'h00);
        checkOutput("glitch_evt_cnt",   32'(evt_cnt - ev0), 32'd2);

        // reset in the middle of a frame
        $display("[TB] reset mid-frame");
        sendPartial(8'h1C, 3);
        #1 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        repeat (10) @(posedge clk);
        er0    = err_cnt;
        ev0    = evt_cnt;
        ev0_al = evt_cnt_al;
        applyStimulus(8'h1C, 1'b0, 1'b0);
        checkOutput("rstmid_odata",    32'(odata),    32'h02);
        checkOutput("rstmid_odata_al", 32'(odata_al), 32'hFD);
        checkOutput("rstmid_err",      32'(err_cnt - er0), 32'd0);
        checkOutput("rstmid_evt",      32'(evt_cnt - ev0), 32'd1);
        checkOutput("al_evt",          32'(evt_cnt_al - ev0_al), 32'd1);
        checkOutput("al_pos",          32'({key_row_al, key_col_al, key_rel_al}), 32'({4'd4, 3'd1, 1'b0}));
        checkOutput("al_shift",        32'(shift_al), 32'h0);
        checkOutput("al_err_total",    32'(err_cnt_al), 32'd2);
        checkOutput("err_total",       32'(err_cnt), 32'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
        $finish;
    end

endmodule
